dc_restorer: RTL and testbench

Output-side counterpart to the input DC-offset stage. Takes zero-centred signed 16-bit audio samples from the processing chain and adds a DC bias to produce unsigned 16-bit codes for the PWM/DAC output driver. The bias ramps up from 0 at enable and back down to 0 at disable, so the speaker sees no step (pop). Includes mute and saturation.

---
 rtl/dc_restorer_pkg.sv | 15 +
 rtl/dc_restorer_sat_add.sv | 25 ++
 rtl/dc_restorer.sv | 117 +++++++++++
 tb/tb_dc_restorer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dc_restorer_pkg.sv
// Shared types and widths for the output-side DC restorer.
package dc_restorer_pkg;

    typedef enum logic [2:0] {
        OFF,
        RAMP_UP,
        RUN,
        MUTE,
        RAMP_DOWN
    } state_t;

    localparam int SAMPLE_W = 16;
    localparam int SUM_W    = 18;

endpackage

// File: rtl/dc_restorer_sat_add.sv
// Signed sample plus unsigned bias, clamped into the unsigned 16-bit DAC code range.
module sat_add_u16
    import dc_restorer_pkg::*;
(
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] bias,
    output logic [SAMPLE_W-1:0] result
);

    logic [SUM_W-1:0] sum;

    always_comb begin
        sum = {{(SUM_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample}
            + {{(SUM_W-SAMPLE_W){1'b0}}, bias};
        // Bit 17 set means the sum went negative; bit 16 alone means it passed full scale.
        if (sum[SUM_W-1]) begin
            result = '0;
        end else if (sum[SAMPLE_W]) begin
            result = '1;
        end else begin
            result = sum[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/dc_restorer.sv
// Adds a ramped DC bias to zero-centred audio for the DAC/PWM driver, with mute
// and saturation; the bias ramps between 0 and BIAS so the speaker never sees a step.
module dc_restorer
    import dc_restorer_pkg::*;
#(
    parameter logic [15:0] BIAS      = 16'h8000,
    parameter logic [15:0] RAMP_STEP = 16'h0040
)
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                ready_in,
    input  logic [SAMPLE_W-1:0] signal_in,
    input  logic                enable_in,
    input  logic                mute_in,
    output logic [SAMPLE_W-1:0] signal_out,
    output logic                done_out,
    output logic                settled_out,
    output state_t              state_out
);

    // ready_in is a one-cycle strobe with no back-pressure: the sample on signal_in
    // is consumed that cycle, and done_out answers it exactly one cycle later.

    state_t              state;
    logic [SAMPLE_W-1:0] bias;
    logic [SAMPLE_W:0]   bias_up_wide;
    logic [SAMPLE_W-1:0] bias_up;
    logic [SAMPLE_W-1:0] bias_dn;
    logic [SAMPLE_W-1:0] run_sample;

    always_comb begin
        bias_up_wide = {1'b0, bias} + {1'b0, RAMP_STEP};
        bias_up      = bias;
        bias_dn      = '0;
        if (bias_up_wide >= {1'b0, BIAS}) begin
            bias_up = BIAS;
        end else begin
            bias_up = bias_up_wide[SAMPLE_W-1:0];
        end
        if (bias > RAMP_STEP) begin
            bias_dn = bias - RAMP_STEP;
        end
    end

    sat_add_u16 u_sat_add (
        .sample (signal_in),
        .bias   (bias),
        .result (run_sample)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= OFF;
            bias        <= '0;
            signal_out  <= '0;
            done_out    <= 1'b0;
            settled_out <= 1'b0;
        end else begin
            done_out <= ready_in;
            case (state)
                OFF: begin
                    if (ready_in) signal_out <= '0;
                    if (enable_in) state <= RAMP_UP;
                end
                RAMP_UP: begin
                    if (ready_in) begin
                        bias       <= bias_up;
                        signal_out <= bias_up;
                    end
                    // Losing enable beats reaching the target on the same cycle.
                    if (!enable_in) begin
                        state <= RAMP_DOWN;
                    end else if (ready_in && bias_up == BIAS) begin
                        state       <= RUN;
                        settled_out <= 1'b1;
                    end
                end
                RUN: begin
                    if (ready_in) signal_out <= run_sample;
                    if (!enable_in) begin
                        state       <= RAMP_DOWN;
                        settled_out <= 1'b0;
                    end else if (mute_in) begin
                        state <= MUTE;
                    end
                end
                MUTE: begin
                    if (ready_in) signal_out <= bias;
                    if (!enable_in) begin
                        state       <= RAMP_DOWN;
                        settled_out <= 1'b0;
                    end else if (!mute_in) begin
                        state <= RUN;
                    end
                end
                RAMP_DOWN: begin
                    // A re-enable is ignored here; OFF picks it up once the bias reaches 0.
                    if (ready_in) begin
                        bias       <= bias_dn;
                        signal_out <= bias_dn;
                        if (bias_dn == '0) state <= OFF;
                    end
                end
                default: begin
                    state       <= OFF;
                    bias        <= '0;
                    signal_out  <= '0;
                    settled_out <= 1'b0;
                end
            endcase
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_dc_restorer.sv
// Directed bench for dc_restorer: default-bias instance plus a BIAS=C000h instance for clipping.
module tb_dc_restorer;
    import dc_restorer_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        ready_in = 1'b0;
    logic [15:0] signal_in = '0;
    logic        enable_a = 1'b0;
    logic        enable_b = 1'b0;
    logic        mute_in = 1'b0;

    logic [15:0] sig_a, sig_b;
    logic        done_a, done_b, settled_a, settled_b;
    state_t      st_a, st_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk_in = ~clk_in;

    dc_restorer u_dut_a (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ready_in    (ready_in),
        .signal_in   (signal_in),
        .enable_in   (enable_a),
        .mute_in     (mute_in),
        .signal_out  (sig_a),
        .done_out    (done_a),
        .settled_out (settled_a),
        .state_out   (st_a)
    );

    dc_restorer #(.BIAS(16'hC000), .RAMP_STEP(16'h1000)) u_dut_b (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ready_in    (ready_in),
        .signal_in   (signal_in),
        .enable_in   (enable_b),
        .mute_in     (1'b0),
        .signal_out  (sig_b),
        .done_out    (done_b),
        .settled_out (settled_b),
        .state_out   (st_b)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One idle cycle, then a one-cycle strobe; outputs for the sample are visible on return.
    task automatic strobe(input logic [15:0] s);
        tick();
        signal_in = s;
        ready_in  = 1'b1;
        tick();
        ready_in  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        logic [15:0] exp_v;

        // Reset
        tick();
        tick();
        rst_in = 1'b0;
        chk("rst_signal", sig_a, 16'h0000);
        chk("rst_done", {15'd0, done_a}, 16'd0);
        chk("rst_settled", {15'd0, settled_a}, 16'd0);
        chk("rst_state", {13'd0, st_a}, {13'd0, OFF});

        // Disabled: output stays 0, done pulses one cycle
        for (int i = 0; i < 3; i++) begin
            strobe(16'h1234 + 16'(i));
            chk("off_signal", sig_a, 16'h0000);
            chk("off_done_hi", {15'd0, done_a}, 16'd1);
            tick();
            chk("off_done_lo", {15'd0, done_a}, 16'd0);
            chk("off_settled", {15'd0, settled_a}, 16'd0);
            tick();
        end

        // Ramp up 0040h..8000h over 512 strobes
        enable_a = 1'b1;
        tick();
        chk("ramp_up_state", {13'd0, st_a}, {13'd0, RAMP_UP});
        for (int i = 1; i <= 512; i++) begin
            strobe(16'h0000);
            exp_v = 16'(i * 16'h0040);
            chk("ramp_up_val", sig_a, exp_v);
            if (i == 511) chk("ramp_up_not_settled", {15'd0, settled_a}, 16'd0);
        end
        chk("run_settled", {15'd0, settled_a}, 16'd1);
        chk("run_state", {13'd0, st_a}, {13'd0, RUN});

        // RUN with default bias: MSB inversion
        strobe(16'h0000); chk("run_0000", sig_a, 16'h8000);
        strobe(16'h7FFF); chk("run_7fff", sig_a, 16'hFFFF);
        strobe(16'h8000); chk("run_8000", sig_a, 16'h0000);
        strobe(16'hFFFF); chk("run_ffff", sig_a, 16'h7FFF);

        // Mute holds output at bias
        mute_in = 1'b1;
        tick();
        chk("mute_state", {13'd0, st_a}, {13'd0, MUTE});
        chk("mute_settled", {15'd0, settled_a}, 16'd1);
        strobe(16'h1234); chk("mute_val", sig_a, 16'h8000);
        mute_in = 1'b0;
        tick();
        strobe(16'h1234); chk("unmute_val", sig_a, 16'h9234);

        // Mute and disable together: ramp-down wins
        mute_in  = 1'b1;
        enable_a = 1'b0;
        tick();
        chk("mute_dis_state", {13'd0, st_a}, {13'd0, RAMP_DOWN});
        chk("mute_dis_settled", {15'd0, settled_a}, 16'd0);
        strobe(16'h1234); chk("ramp_dn_first", sig_a, 16'h7FC0);
        mute_in = 1'b0;
        for (int i = 0; i < 600 && st_a != OFF; i++) strobe(16'h0000);
        chk("ramp_dn_end_val", sig_a, 16'h0000);
        chk("ramp_dn_end_state", {13'd0, st_a}, {13'd0, OFF});

        // Ramp up to 2000h, then drop enable
        enable_a = 1'b1;
        tick();
        for (int i = 0; i < 128; i++) strobe(16'h0000);
        chk("mid_ramp_val", sig_a, 16'h2000);
        chk("mid_ramp_state", {13'd0, st_a}, {13'd0, RAMP_UP});
        enable_a = 1'b0;
        tick();
        chk("mid_drop_state", {13'd0, st_a}, {13'd0, RAMP_DOWN});
        for (int k = 1; k <= 128; k++) begin
            if (k == 64) enable_a = 1'b1;
            strobe(16'h0000);
            exp_v = 16'h2000 - 16'(k * 16'h0040);
            chk("mid_dn_val", sig_a, exp_v);
        end
        chk("mid_dn_state_off", {13'd0, st_a}, {13'd0, OFF});
        tick();
        chk("reenter_ramp_up", {13'd0, st_a}, {13'd0, RAMP_UP});
        strobe(16'h0000); chk("reup_1", sig_a, 16'h0040);
        strobe(16'h0000); chk("reup_2", sig_a, 16'h0080);

        // Reset during ramp-down
        enable_a = 1'b0;
        tick();
        strobe(16'h0000); chk("pre_rst_dn", sig_a, 16'h0040);
        rst_in = 1'b1;
        tick();
        chk("mid_rst_signal", sig_a, 16'h0000);
        chk("mid_rst_settled", {15'd0, settled_a}, 16'd0);
        chk("mid_rst_state", {13'd0, st_a}, {13'd0, OFF});
        rst_in = 1'b0;

        // BIAS=C000h instance: ramp in 1000h steps, then clamp
        enable_b = 1'b1;
        tick();
        for (int i = 1; i <= 12; i++) begin
            strobe(16'h0000);
            exp_v = 16'(i * 16'h1000);
            chk("b_ramp_val", sig_b, exp_v);
        end
        chk("b_state", {13'd0, st_b}, {13'd0, RUN});
        chk("b_settled", {15'd0, settled_b}, 16'd1);
        strobe(16'h7000); chk("b_clip_hi", sig_b, 16'hFFFF);
        strobe(16'h8000); chk("b_neg", sig_b, 16'h4000);
        strobe(16'h0123); chk("b_small", sig_b, 16'hC123);
        chk("a_still_off", sig_a, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
